// File: rtl/door_lock_ctrl.sv
// Door actuator, failed-attempt lockout and held-open alarm stage behind the password comparator.
// Optional forced-entry alarm in IDLE/LOCKOUT is enabled by defining DOOR_FORCED_ALARM_EN.
module door_lock_ctrl #(
    parameter int unsigned OPEN_CYCLES    = 16,
    parameter int unsigned CLOSE_CYCLES   = 32,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 64,
    parameter int unsigned FAIL_W         = 4,
    parameter int unsigned TMR_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              check_valid,
    input  logic              unlock_door,
    input  logic              door_closed,
    input  logic              admin_clear,
    output logic              ready,
    output logic              door_open,
    output logic              locked_out,
    output logic              alarm,
    output logic [FAIL_W-1:0] fail_count
);

    typedef enum logic [1:0] {
        StIdle,
        StOpen,
        StWaitClose,
        StLockout
    } stateT;

    localparam logic [TMR_W-1:0]  OpenLoad    = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0]  CloseLoad   = TMR_W'(CLOSE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LockoutLoad = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0] MaxFails    = FAIL_W'(MAX_FAILS);

    stateT             stateQ;
    logic [TMR_W-1:0]  timerQ;
    logic              timerZero;
    logic [FAIL_W-1:0] failNext;
    logic              attemptTaken;

    assign ready     = (stateQ == StIdle);
    assign timerZero = (timerQ == '0);

    // Saturating increment; lockout normally fires before saturation is reachable.
    assign failNext = (fail_count >= MaxFails) ? fail_count : fail_count + 1'b1;

    // admin_clear consumes the cycle in IDLE, so a coincident attempt is dropped.
    assign attemptTaken = check_valid && !admin_clear;

`ifdef DOOR_FORCED_ALARM_EN
    logic doorAjarQ;
    logic doorAjarNow;
    logic forcedAlarm;

    assign doorAjarNow = ((stateQ == StIdle) || (stateQ == StLockout)) && !door_closed;
    assign forcedAlarm = doorAjarNow && doorAjarQ;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ     <= StIdle;
            timerQ     <= '0;
            fail_count <= '0;
            door_open  <= 1'b0;
            locked_out <= 1'b0;
            alarm      <= 1'b0;
`ifdef DOOR_FORCED_ALARM_EN
            doorAjarQ  <= 1'b0;
`endif
        end else begin
            if (admin_clear) begin
                fail_count <= '0;
            end

            case (stateQ)
                StIdle: begin
                    if (attemptTaken) begin
                        if (unlock_door) begin
                            stateQ     <= StOpen;
                            timerQ     <= OpenLoad;
                            fail_count <= '0;
                            door_open  <= 1'b1;
                        end else begin
                            fail_count <= failNext;
                            if (failNext == MaxFails) begin
                                stateQ     <= StLockout;
                                timerQ     <= LockoutLoad;
                                locked_out <= 1'b1;
                            end
                        end
                    end
                end

                StOpen: begin
                    if (timerZero) begin
                        stateQ    <= StWaitClose;
                        timerQ    <= CloseLoad;
                        door_open <= 1'b0;
                    end else begin
                        timerQ <= timerQ - 1'b1;
                    end
                end

                StWaitClose: begin
                    if (door_closed) begin
                        stateQ <= StIdle;
                        timerQ <= '0;
                    end else if (timerZero) begin
                        // Hold at zero until the door shuts; alarm stays asserted.
                        alarm <= 1'b1;
                    end else begin
                        timerQ <= timerQ - 1'b1;
                    end
                end

                StLockout: begin
                    if (admin_clear || timerZero) begin
                        stateQ     <= StIdle;
                        timerQ     <= '0;
                        fail_count <= '0;
                        locked_out <= 1'b0;
                    end else begin
                        timerQ <= timerQ - 1'b1;
                    end
                end

                default: begin
                    stateQ     <= StIdle;
                    timerQ     <= '0;
                    door_open  <= 1'b0;
                    locked_out <= 1'b0;
                end
            endcase

`ifdef DOOR_FORCED_ALARM_EN
            doorAjarQ <= doorAjarNow;
            if (forcedAlarm) begin
                alarm <= 1'b1;
            end
`endif

            // Last assignment wins: clear beats any alarm source set this cycle.
            if (admin_clear) begin
                alarm <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Randomised and directed checks of door_lock_ctrl against a phase/age reference model.
module tb_door_lock_ctrl;

    localparam int OpenC  = 16;
    localparam int CloseC = 32;
    localparam int MaxF   = 3;
    localparam int LockC  = 64;

    localparam int MIdle = 0;
    localparam int MOpen = 1;
    localparam int MWait = 2;
    localparam int MLock = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       check_valid = 1'b0;
    logic       unlock_door = 1'b0;
    logic       door_closed = 1'b1;
    logic       admin_clear = 1'b0;
    logic       ready;
    logic       door_open;
    logic       locked_out;
    logic       alarm;
    logic [3:0] fail_count;

    int nChecks = 0;
    int nFails = 0;

    // Reference model: current phase, cycles already spent in it, and visible counters.
    int mPhase;
    int mAge;
    int mFailCnt;
    int mAlarm;
    int mPrevAjar;

    door_lock_ctrl #(
        .OPEN_CYCLES   (OpenC),
        .CLOSE_CYCLES  (CloseC),
        .MAX_FAILS     (MaxF),
        .LOCKOUT_CYCLES(LockC),
        .FAIL_W        (4),
        .TMR_W         (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .check_valid(check_valid),
        .unlock_door(unlock_door),
        .door_closed(door_closed),
        .admin_clear(admin_clear),
        .ready      (ready),
        .door_open  (door_open),
        .locked_out (locked_out),
        .alarm      (alarm),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input int got, input int exp);
        nChecks++;
        if (got != exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPhase    = MIdle;
        mAge      = 0;
        mFailCnt  = 0;
        mAlarm    = 0;
        mPrevAjar = 0;
    endtask

    task automatic modelStep();
        int ajar;
        int forced;
        ajar   = ((mPhase == MIdle || mPhase == MLock) && !door_closed) ? 1 : 0;
        forced = 0;
`ifdef DOOR_FORCED_ALARM_EN
        forced = ajar & mPrevAjar;
`endif
        if (admin_clear) begin
            mFailCnt = 0;
        end
        case (mPhase)
            MIdle: begin
                if (check_valid && !admin_clear) begin
                    if (unlock_door) begin
                        mPhase   = MOpen;
                        mAge     = 0;
                        mFailCnt = 0;
                    end else begin
                        mFailCnt = (mFailCnt + 1 > MaxF) ? MaxF : mFailCnt + 1;
                        if (mFailCnt == MaxF) begin
                            mPhase = MLock;
                            mAge   = 0;
                        end
                    end
                end
            end
            MOpen: begin
                mAge++;
                if (mAge == OpenC) begin
                    mPhase = MWait;
                    mAge   = 0;
                end
            end
            MWait: begin
                if (door_closed) begin
                    mPhase = MIdle;
                end else begin
                    mAge++;
                    if (mAge >= CloseC) mAlarm = 1;
                end
            end
            default: begin
                mAge++;
                if (admin_clear || mAge == LockC) begin
                    mPhase   = MIdle;
                    mFailCnt = 0;
                end
            end
        endcase
        if (forced != 0) mAlarm = 1;
        if (admin_clear) mAlarm = 0;
        mPrevAjar = ajar;
    endtask

    task automatic checkAll(input string ctx);
        checkEq({ctx, ".ready"}, int'(ready), (mPhase == MIdle) ? 1 : 0);
        checkEq({ctx, ".door_open"}, int'(door_open), (mPhase == MOpen) ? 1 : 0);
        checkEq({ctx, ".locked_out"}, int'(locked_out), (mPhase == MLock) ? 1 : 0);
        checkEq({ctx, ".alarm"}, int'(alarm), mAlarm);
        checkEq({ctx, ".fail_count"}, int'(fail_count), mFailCnt);
    endtask

    // One clock: DUT and model both consume the inputs held since the last falling edge.
    task automatic tick(input string ctx);
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkAll(ctx);
    endtask

    task automatic quiet();
        check_valid = 1'b0;
        unlock_door = 1'b0;
        admin_clear = 1'b0;
    endtask

    task automatic attempt(input string ctx, input logic grant);
        check_valid = 1'b1;
        unlock_door = grant;
        tick(ctx);
        quiet();
    endtask

    task automatic settleIdle(input string ctx);
        door_closed = 1'b1;
        for (int i = 0; i < 200 && !ready; i++) tick(ctx);
        checkEq({ctx, ".settled"}, int'(ready), 1);
    endtask

    initial begin
        int openLen;
        int lockLen;
        int doorRun;
        logic doorHeld;

        modelReset();
        #1;
        checkEq("reset.ready", int'(ready), 1);
        checkEq("reset.door_open", int'(door_open), 0);
        checkEq("reset.locked_out", int'(locked_out), 0);
        checkEq("reset.alarm", int'(alarm), 0);
        checkEq("reset.fail_count", int'(fail_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick("idle");

        // Grant: door open for exactly OPEN_CYCLES, back to ready after the door shuts.
        door_closed = 1'b0;
        attempt("grant", 1'b1);
        openLen = 0;
        for (int i = 0; i < 17; i++) begin
            if (door_open) openLen++;
            tick("grant.run");
        end
        checkEq("grant.openLen", openLen, OpenC);
        checkEq("grant.readyLow", int'(ready), 0);
        door_closed = 1'b1;
        tick("grant.close");
        checkEq("grant.readyBack", int'(ready), 1);

        // Lockout after MAX_FAILS failures; attempts during lockout are ignored.
        attempt("fail1", 1'b0);
        checkEq("lock.fc1", int'(fail_count), 1);
        attempt("fail2", 1'b0);
        checkEq("lock.fc2", int'(fail_count), 2);
        attempt("fail3", 1'b0);
        checkEq("lock.fc3", int'(fail_count), 3);
        lockLen = 0;
        for (int i = 0; i < 200 && locked_out; i++) begin
            lockLen++;
            check_valid = 1'($urandom_range(0, 1));
            unlock_door = 1'($urandom_range(0, 1));
            tick("lock.run");
        end
        quiet();
        checkEq("lock.len", lockLen, LockC);
        checkEq("lock.fcAfter", int'(fail_count), 0);
        checkEq("lock.readyAfter", int'(ready), 1);

        // Two failures then a grant: count resets, no lockout.
        attempt("fg.fail1", 1'b0);
        attempt("fg.fail2", 1'b0);
        checkEq("fg.fc2", int'(fail_count), 2);
        attempt("fg.grant", 1'b1);
        checkEq("fg.fc0", int'(fail_count), 0);
        checkEq("fg.noLock", int'(locked_out), 0);
        settleIdle("fg.settle");

        // Held open: alarm one cycle after the last WAIT_CLOSE cycle, sticky after closing.
        door_closed = 1'b0;
        attempt("held.grant", 1'b1);
        for (int i = 0; i < OpenC + CloseC - 1; i++) tick("held.run");
        checkEq("held.alarmPre", int'(alarm), 0);
        tick("held.timeout");
        checkEq("held.alarm", int'(alarm), 1);
        door_closed = 1'b1;
        tick("held.close");
        tick("held.idle");
        checkEq("held.sticky", int'(alarm), 1);
        admin_clear = 1'b1;
        tick("held.clear");
        quiet();
        checkEq("held.cleared", int'(alarm), 0);

        // admin_clear at lockout cycle 10.
        attempt("ac.f1", 1'b0);
        attempt("ac.f2", 1'b0);
        attempt("ac.f3", 1'b0);
        for (int i = 0; i < 9; i++) tick("ac.lock");
        checkEq("ac.stillLocked", int'(locked_out), 1);
        admin_clear = 1'b1;
        tick("ac.clear");
        quiet();
        checkEq("ac.unlocked", int'(locked_out), 0);
        checkEq("ac.fc", int'(fail_count), 0);

        // Asynchronous reset in the middle of OPEN.
        attempt("rst.grant", 1'b1);
        for (int i = 0; i < 5; i++) tick("rst.open");
        checkEq("rst.openBefore", int'(door_open), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkEq("rst.doorAsync", int'(door_open), 0);
        checkEq("rst.readyAsync", int'(ready), 1);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        tick("rst.after");

        // Door ajar in IDLE: alarm only with the forced-entry option built in.
        door_closed = 1'b0;
        for (int i = 0; i < 3; i++) tick("forced");
`ifdef DOOR_FORCED_ALARM_EN
        checkEq("forced.alarm", int'(alarm), 1);
`else
        checkEq("forced.alarm", int'(alarm), 0);
`endif
        door_closed = 1'b1;
        admin_clear = 1'b1;
        tick("forced.clear");
        quiet();

        // Random traffic with long door-held runs to reach the held-open timeout.
        doorRun  = 0;
        doorHeld = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (doorRun == 0) begin
                doorHeld = ($urandom_range(0, 3) == 0);
                doorRun  = int'($urandom_range(1, 60));
            end
            doorRun--;
            door_closed = !doorHeld;
            check_valid = ($urandom_range(0, 5) == 0);
            unlock_door = 1'($urandom_range(0, 1));
            admin_clear = ($urandom_range(0, 79) == 0);
            tick("rand");
        end
        quiet();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
